twos_complement_restorer32: RTL

- Multi-cycle 32-bit two's-complement unit. It completes the negation path that starts with the bitwise flipper: ~x followed by +1.
- Supported operations: negate, absolute value, pass, or "restore" (+1 applied to an operand that is already ones-complemented).
- Carry ripples CHUNK bits per cycle to keep the logic per cycle small.
- Sits ahead of and behind the multi-cycle multiplier/divider datapath, using a valid/ready handshake on both sides.

---
 rtl/twos_complement_restorer32_pkg.sv | 18 +
 rtl/twos_chunk_slice.sv | 18 +
 rtl/twos_complement_restorer32.sv | 130 +++++++++++++
 3 files changed

// File: rtl/twos_complement_restorer32_pkg.sv
// Shared encodings for the multi-cycle two's-complement restorer:
// operation modes, FSM states and the one non-negatable operand value.
package twos_complement_restorer32_pkg;

  localparam logic [1:0] MODE_NEG     = 2'b00;
  localparam logic [1:0] MODE_ABS     = 2'b01;
  localparam logic [1:0] MODE_PASS    = 2'b10;
  localparam logic [1:0] MODE_RESTORE = 2'b11;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/twos_chunk_slice.sv
// One CHUNK-wide step of the ripple: optional bitwise invert, then add the
// incoming carry.
module twos_chunk_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic         inv,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  // Invert-and-increment with the carry-out kept as the top bit
  always_comb begin
    {cout, s} = {1'b0, a ^ {W{inv}}} + {{W{1'b0}}, cin};
  end

endmodule

// File: rtl/twos_complement_restorer32.sv
// Multi-cycle 32-bit negate / abs / pass / restore unit. The carry ripples
// CHUNK bits per cycle, with valid/ready handshakes on both sides.
module twos_complement_restorer32
  import twos_complement_restorer32_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  input  logic [1:0]  mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow
);

  localparam int NCHUNK = 32 / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (!(CHUNK == 1 || CHUNK == 2 || CHUNK == 4 || CHUNK == 8 ||
        CHUNK == 16 || CHUNK == 32)) begin : g_bad_chunk
    $error("twos_complement_restorer32: CHUNK must be 1, 2, 4, 8, 16 or 32");
  end

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [31:0]       opnd_q, opnd_d;
  logic [31:0]       result_q, result_d;
  logic              carry_q, carry_d;
  logic              inv_q, inv_d;
  logic              ovf_q, ovf_d;
  logic              accept_s, last_s;
  logic [CHUNK-1:0]  slice_s;
  logic              cout_s;

  assign accept_s = in_valid && in_ready;
  assign last_s   = (cnt_q == CW'(NCHUNK - 1));

  // The operand register shifts right, so the active chunk is always at bit 0
  twos_chunk_slice #(.W(CHUNK)) u_slice (
    .a    (opnd_q[CHUNK-1:0]),
    .inv  (inv_q),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (cout_s)
  );

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_s)  state_d = RUN;  else state_d = IDLE;
      RUN:     if (last_s)    state_d = DONE; else state_d = RUN;
      DONE:    if (out_ready) state_d = IDLE; else state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready  = (state_q == IDLE) && !reset;
    out_valid = (state_q == DONE);
  end

  // Datapath next-state: load on acceptance, one chunk per RUN cycle
  always_comb begin
    cnt_d    = cnt_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    carry_d  = carry_q;
    inv_d    = inv_q;
    ovf_d    = ovf_q;
    if (accept_s) begin
      opnd_d   = x;
      result_d = 32'h0000_0000;
      cnt_d    = '0;
      ovf_d    = ((mode == MODE_NEG) || (mode == MODE_ABS)) && (x == INT_MIN);
      case (mode)
        MODE_NEG:     begin inv_d = 1'b1; carry_d = 1'b1;  end
        MODE_ABS:     begin inv_d = x[31]; carry_d = x[31]; end
        MODE_PASS:    begin inv_d = 1'b0; carry_d = 1'b0;  end
        MODE_RESTORE: begin inv_d = 1'b0; carry_d = 1'b1;  end
        default:      begin inv_d = 1'b0; carry_d = 1'b0;  end
      endcase
    end else if (state_q == RUN) begin
      // New chunk enters at the top; after NCHUNK steps chunk 0 sits at bit 0
      result_d = 32'({slice_s, result_q} >> CHUNK);
      opnd_d   = opnd_q >> CHUNK;
      carry_d  = cout_s;
      cnt_d    = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= '0;
      opnd_q   <= 32'h0000_0000;
      result_q <= 32'h0000_0000;
      carry_q  <= 1'b0;
      inv_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      inv_q    <= inv_d;
      ovf_q    <= ovf_d;
    end
  end

  assign result   = result_q;
  assign overflow = ovf_q;

endmodule
